mem_arbiter: RTL and testbench

- Shares the core's single memory port between two requesters: the core control/datapath and the debug module's system-bus access path.
- Sits between those requesters and the memory/bus slave.
- Passes the selected request through combinationally, locks ownership until the slave signals completion, and routes completion back to the owner only.
- Debug has priority; a burst limiter prevents debug from starving core fetch.

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester memory port arbiter (debug priority, burst-limited)
// Optional slave-hang abort enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_DBG_BURST = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    core_read,
  input  logic                    core_write,
  input  logic [ADDR_WIDTH-1:0]   core_addr,
  input  logic [DATA_WIDTH-1:0]   core_wdata,
  input  logic [DATA_WIDTH/8-1:0] core_be,
  output logic                    core_done,
  output logic                    core_err,
  input  logic                    dbg_read,
  input  logic                    dbg_write,
  input  logic [ADDR_WIDTH-1:0]   dbg_addr,
  input  logic [DATA_WIDTH-1:0]   dbg_wdata,
  input  logic [DATA_WIDTH/8-1:0] dbg_be,
  output logic                    dbg_done,
  output logic                    dbg_err,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_done,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int BW = (MAX_DBG_BURST < 2) ? 1 : $clog2(MAX_DBG_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DBG_BURST);

  typedef enum logic [1:0] {IDLE, OWN_CORE, OWN_DBG} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [BW-1:0] r_burst;

  logic w_core_req;
  logic w_dbg_req;
  logic w_grant_dbg;
  logic w_sel_core;
  logic w_sel_dbg;
  logic w_to_hit;
  logic w_complete;
  logic w_wr_src;
  logic w_rd_src;

  assign w_core_req  = core_read | core_write;
  assign w_dbg_req   = dbg_read | dbg_write;
  // Debug loses only when its burst allowance is spent and core is waiting.
  assign w_grant_dbg = w_dbg_req && !((r_burst == BURST_MAX) && w_core_req);
  assign w_complete  = mem_done | w_to_hit;

  always_comb begin
    w_sel_core = 1'b0;
    w_sel_dbg  = 1'b0;
    w_next     = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_dbg) begin
          w_sel_dbg = 1'b1;
          if (!mem_done) w_next = OWN_DBG;
        end else if (w_core_req) begin
          w_sel_core = 1'b1;
          if (!mem_done) w_next = OWN_CORE;
        end
      end
      OWN_CORE: begin
        w_sel_core = 1'b1;
        if (w_complete) w_next = IDLE;
      end
      OWN_DBG: begin
        w_sel_dbg = 1'b1;
        if (w_complete) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_burst <= '0;
    end else begin
      r_state <= w_next;
      if (w_sel_dbg && w_complete) begin
        if (!w_core_req)
          r_burst <= '0;
        else if (r_burst != BURST_MAX)
          r_burst <= r_burst + 1'b1;
      end else if (w_sel_core && w_complete) begin
        r_burst <= '0;
      end
    end
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TIMEOUT + 1);
  localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_to_cnt;

  // Held at zero in IDLE so it starts from zero on entry to an OWN state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_to_cnt <= '0;
    else if (r_state == IDLE)
      r_to_cnt <= '0;
    else if (!mem_done)
      r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_to_hit = (r_state != IDLE) && !mem_done && (r_to_cnt == TO_LAST);
`else
  assign w_to_hit = 1'b0;
`endif

  assign w_wr_src = w_sel_dbg ? dbg_write : (w_sel_core ? core_write : 1'b0);
  assign w_rd_src = w_sel_dbg ? (dbg_read & ~dbg_write)
                              : (w_sel_core ? (core_read & ~core_write) : 1'b0);

  // Every output is gated by rst_n so reset forces zeros without waiting for a clock.
  assign mem_write = rst_n & w_wr_src & ~w_to_hit;
  assign mem_read  = rst_n & w_rd_src & ~w_to_hit;
  assign mem_addr  = !rst_n ? '0 : (w_sel_dbg ? dbg_addr  : (w_sel_core ? core_addr  : '0));
  assign mem_wdata = !rst_n ? '0 : (w_sel_dbg ? dbg_wdata : (w_sel_core ? core_wdata : '0));
  assign mem_be    = !rst_n ? '0 : (w_sel_dbg ? dbg_be    : (w_sel_core ? core_be    : '0));
  assign rdata     = !rst_n ? '0 : mem_rdata;

  assign core_done = rst_n & w_sel_core & w_complete;
  assign dbg_done  = rst_n & w_sel_dbg  & w_complete;
  assign core_err  = rst_n & w_sel_core & w_to_hit;
  assign dbg_err   = rst_n & w_sel_dbg  & w_to_hit;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized bench for mem_arbiter
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXB = 4;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_read, core_write, dbg_read, dbg_write;
  logic [AW-1:0] core_addr, dbg_addr, mem_addr;
  logic [DW-1:0] core_wdata, dbg_wdata, mem_wdata, rdata, mem_rdata;
  logic [3:0]    core_be, dbg_be, mem_be;
  logic          core_done, core_err, dbg_done, dbg_err;
  logic          mem_read, mem_write, mem_done;

  int total = 0;
  int bad   = 0;

  int m_owner;
  int m_streak;
  int m_age;

  logic          o_cd, o_dd, o_ce, o_rd;
  logic [31:0]   o_addr, o_rdata;
  logic [9:0]    seq;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DBG_BURST(MAXB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_read(core_read), .core_write(core_write), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_be(core_be), .core_done(core_done), .core_err(core_err),
    .dbg_read(dbg_read), .dbg_write(dbg_write), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_be(dbg_be), .dbg_done(dbg_done), .dbg_err(dbg_err),
    .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: settle, check against the transaction-level model, advance the model.
  task automatic cyc();
    int          w;
    logic        cr, dr, hit, fin, ew, er;
    logic [31:0] ea, ewd, ebe;
    #3;
    cr  = core_read | core_write;
    dr  = dbg_read | dbg_write;
    w   = 0;
    hit = 1'b0;
    if (rst_n) begin
      if (m_owner != 0) w = m_owner;
      else if (dr && !(m_streak == MAXB && cr)) w = 2;
      else if (cr) w = 1;
`ifdef MEM_ARBITER_TIMEOUT_EN
      hit = (m_owner != 0) && !mem_done && (m_age == TO);
`endif
    end
    fin = (w != 0) && (mem_done || hit);
    ew = 1'b0; er = 1'b0; ea = '0; ewd = '0; ebe = '0;
    if (w == 1) begin
      ew = core_write; er = core_read & ~core_write;
      ea = core_addr; ewd = core_wdata; ebe = 32'(core_be);
    end else if (w == 2) begin
      ew = dbg_write; er = dbg_read & ~dbg_write;
      ea = dbg_addr; ewd = dbg_wdata; ebe = 32'(dbg_be);
    end
    if (hit) begin ew = 1'b0; er = 1'b0; end
    chk("mem_read",  32'(mem_read),  32'(er));
    chk("mem_write", 32'(mem_write), 32'(ew));
    chk("mem_addr",  mem_addr,  ea);
    chk("mem_wdata", mem_wdata, ewd);
    chk("mem_be",    32'(mem_be), ebe);
    chk("core_done", 32'(core_done), 32'(fin && w == 1));
    chk("dbg_done",  32'(dbg_done),  32'(fin && w == 2));
    chk("core_err",  32'(core_err),  32'(hit && w == 1));
    chk("dbg_err",   32'(dbg_err),   32'(hit && w == 2));
    chk("rdata",     rdata, rst_n ? mem_rdata : 32'h0);
    o_cd = core_done; o_dd = dbg_done; o_ce = core_err;
    o_rd = mem_read;  o_addr = mem_addr; o_rdata = rdata;
    if (!rst_n) begin
      m_owner = 0; m_streak = 0; m_age = 0;
    end else if (fin) begin
      if (w == 2) m_streak = cr ? ((m_streak < MAXB) ? m_streak + 1 : MAXB) : 0;
      else        m_streak = 0;
      m_owner = 0;
    end else if (w != 0) begin
      m_age   = (m_owner == 0) ? 1 : m_age + 1;
      m_owner = w;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_read = 0; core_write = 0; core_addr = '0; core_wdata = '0; core_be = '0;
    dbg_read  = 0; dbg_write  = 0; dbg_addr  = '0; dbg_wdata  = '0; dbg_be  = '0;
    mem_done  = 0;
  endtask

  initial begin
    bit cbusy, dbusy;
    int k;
    m_owner = 0; m_streak = 0; m_age = 0;
    rst_n = 1'b0;
    idle_inputs();
    core_read = 1; core_addr = 32'h44; dbg_write = 1; dbg_addr = 32'h88;
    dbg_be = 4'hF; mem_done = 1; mem_rdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    cyc();
    cyc();
    idle_inputs();
    rst_n = 1'b1;
    cyc();

    // Core read with two-cycle slave latency
    core_read = 1; core_addr = 32'h100; core_be = 4'hF;
    cyc();
    chk("t1_rd_c0", 32'(o_rd), 32'd1);
    chk("t1_addr_c0", o_addr, 32'h100);
    cyc();
    mem_done = 1; mem_rdata = 32'hDEADBEEF;
    cyc();
    chk("t1_core_done", 32'(o_cd), 32'd1);
    chk("t1_rdata", o_rdata, 32'hDEADBEEF);
    chk("t1_dbg_done", 32'(o_dd), 32'd0);
    idle_inputs();
    cyc();

    // Simultaneous requests: debug first, core in the following IDLE cycle
    dbg_write = 1; dbg_addr = 32'h200; dbg_wdata = 32'h12345678; dbg_be = 4'hF;
    core_read = 1; core_addr = 32'h300; core_be = 4'h3;
    cyc();
    chk("t2_first_addr", o_addr, 32'h200);
    mem_done = 1;
    cyc();
    chk("t2_dbg_done", 32'(o_dd), 32'd1);
    dbg_write = 0; mem_done = 0;
    cyc();
    chk("t2_core_grant", o_addr, 32'h300);
    mem_done = 1;
    cyc();
    chk("t2_core_done", 32'(o_cd), 32'd1);
    idle_inputs();
    cyc();

    // Debug arrives while core owns; core keeps the port until mem_done
    core_read = 1; core_addr = 32'h400;
    cyc();
    dbg_read = 1; dbg_addr = 32'h500;
    cyc();
    chk("t3_hold1", o_addr, 32'h400);
    cyc();
    chk("t3_hold2", o_addr, 32'h400);
    mem_done = 1;
    cyc();
    chk("t3_core_done", 32'(o_cd), 32'd1);
    core_read = 0; mem_done = 0;
    cyc();
    chk("t3_dbg_grant", o_addr, 32'h500);
    mem_done = 1;
    cyc();
    idle_inputs();
    cyc();

    // Burst limiter with continuous requests and a single-cycle slave
    core_read = 1; core_addr = 32'h600; dbg_read = 1; dbg_addr = 32'h700; mem_done = 1;
    seq = '0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      seq = {seq[8:0], o_dd};
    end
    chk("t4_grant_order", 32'(seq), 32'(10'b1111011110));
    idle_inputs();
    cyc();

    // Async reset in OWN_DBG, after building up a debug streak
    core_read = 1; core_addr = 32'h610; dbg_read = 1; dbg_addr = 32'h710; mem_done = 1;
    cyc(); cyc(); cyc();
    mem_done = 0;
    cyc();
    mem_done = 1;
    #1;
    chk("t5_pre_done", 32'(dbg_done), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_read", 32'(mem_read), 32'd0);
    chk("t5_rst_write", 32'(mem_write), 32'd0);
    chk("t5_rst_ddone", 32'(dbg_done), 32'd0);
    chk("t5_rst_cdone", 32'(core_done), 32'd0);
    chk("t5_rst_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    cyc();
    rst_n = 1'b1;
    seq = '0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      seq = {seq[8:0], o_dd};
    end
    chk("t5_post_order", 32'(seq), 32'(5'b11110));
    idle_inputs();
    cyc();

`ifdef MEM_ARBITER_TIMEOUT_EN
    // Hung slave on a core read, then a normal debug access
    core_read = 1; core_addr = 32'h800;
    for (int i = 0; i < TO; i++) begin
      cyc();
      chk("t6_no_early_done", 32'(o_cd), 32'd0);
    end
    cyc();
    chk("t6_to_done", 32'(o_cd), 32'd1);
    chk("t6_to_err", 32'(o_ce), 32'd1);
    core_read = 0; mem_done = 1;
    cyc();
    mem_done = 0; dbg_read = 1; dbg_addr = 32'h900;
    cyc();
    mem_done = 1;
    cyc();
    chk("t6_dbg_done", 32'(o_dd), 32'd1);
    idle_inputs();
    cyc();
`endif

    // Randomized traffic against the model
    cbusy = 0; dbusy = 0;
    for (int n = 0; n < 400; n++) begin
      if (!cbusy && $urandom_range(0, 1) == 1) begin
        cbusy = 1; k = $urandom_range(0, 3);
        core_read = (k != 1); core_write = (k == 1 || k == 2);
        core_addr = $urandom; core_wdata = $urandom; core_be = 4'($urandom);
      end
      if (!dbusy && $urandom_range(0, 1) == 1) begin
        dbusy = 1; k = $urandom_range(0, 3);
        dbg_read = (k != 1); dbg_write = (k == 1 || k == 2);
        dbg_addr = $urandom; dbg_wdata = $urandom; dbg_be = 4'($urandom);
      end
      mem_done  = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      cyc();
      if (o_cd) begin cbusy = 0; core_read = 0; core_write = 0; end
      if (o_dd) begin dbusy = 0; dbg_read = 0; dbg_write = 0; end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
